// File: rtl/seg_mux_scheduler.sv
// rtl/seg_mux_scheduler.sv - two-digit seven-segment time-multiplexing scheduler
//
// Shares one hex-to-seven-segment decoder and one segment bus between the two
// digits of a dual display. Each digit is driven for ON_CYCLES cycles per
// frame. Optionally, an all-off interval of BLANK_CYCLES cycles separates the
// digits to suppress ghosting.
//
// Build option:
//   SEG_MUX_BLANK_EN  defined   -> SHOW0, BLANK0, SHOW1, BLANK1 schedule
//                     undefined -> SHOW0, SHOW1 only; BLANK_CYCLES unused
//
// Parameters:
//   ON_CYCLES     cycles each digit is driven per frame (>= 2)
//   BLANK_CYCLES  cycles of all-off between digits (>= 1, blanking builds only)
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   s0     in   [3:0] nibble for digit 0, captured when SHOW0 is entered
//   s1     in   [3:0] nibble for digit 1, captured when SHOW1 is entered
//   hex    out  [3:0] nibble presented to the shared decoder
//   an     out  [1:0] active-low anode enables, an[0] = digit 0
//   digit  out  index of the digit currently owning the bus
//   frame  out  one-cycle pulse on the first cycle of every SHOW0

module seg_mux_scheduler #(
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] hex,
    output logic [1:0] an,
    output logic       digit,
    output logic       frame
);

    // The counter only has to reach the larger of the two terminal values,
    // so it is sized from the larger interval length.
    localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
`ifdef SEG_MUX_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

    // The encoding keeps bit 1 as the owning digit, but digit is still
    // decoded explicitly below so the encoding may change freely.
    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   count_q;
    logic [3:0]      h0_q;
    logic [3:0]      h1_q;

    logic            state_change;
    logic            enter_show0;
    logic            enter_show1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW0: begin
                if (count_q == ON_LAST) begin
`ifdef SEG_MUX_BLANK_EN
                    state_d = BLANK0;
`else
                    state_d = SHOW1;
`endif
                end
            end
            SHOW1: begin
                if (count_q == ON_LAST) begin
`ifdef SEG_MUX_BLANK_EN
                    state_d = BLANK1;
`else
                    state_d = SHOW0;
`endif
                end
            end
`ifdef SEG_MUX_BLANK_EN
            BLANK0: begin
                if (count_q == BLANK_LAST) begin
                    state_d = SHOW1;
                end
            end
            BLANK1: begin
                if (count_q == BLANK_LAST) begin
                    state_d = SHOW0;
                end
            end
`endif
            // Without blanking the BLANK states are unreachable; recover to
            // the start of the frame should one ever be observed.
            default: state_d = SHOW0;
        endcase
    end

    assign state_change = (state_d != state_q);
    assign enter_show0  = state_change && (state_d == SHOW0);
    assign enter_show1  = state_change && (state_d == SHOW1);

    // ------------------------------------------------------------------
    // State, counter and holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset counts as entering SHOW0 but deliberately loads zero,
            // so the first frame after reset shows 0 rather than s0.
            state_q <= SHOW0;
            count_q <= '0;
            h0_q    <= 4'h0;
            h1_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            if (state_change) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CW'(1);
            end
            // Inputs are sampled only at the start of a digit's slot so a
            // digit can never change while it is lit.
            if (enter_show0) begin
                h0_q <= s0;
            end
            if (enter_show1) begin
                h1_q <= s1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs: state and holding registers only, no path from s0/s1
    // ------------------------------------------------------------------
    always_comb begin
        digit = 1'b0;
        an    = 2'b11;
        case (state_q)
            SHOW0: begin
                digit = 1'b0;
                an    = 2'b10;
            end
            BLANK0: begin
                digit = 1'b0;
                an    = 2'b11;
            end
            SHOW1: begin
                digit = 1'b1;
                an    = 2'b01;
            end
            BLANK1: begin
                digit = 1'b1;
                an    = 2'b11;
            end
            default: begin
                digit = 1'b0;
                an    = 2'b11;
            end
        endcase
    end

    // During blanking hex keeps the value of the digit that just finished,
    // which avoids a spurious decoder transition while the anodes are off.
    assign hex   = digit ? h1_q : h0_q;
    assign frame = (state_q == SHOW0) && (count_q == '0);

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// tb/tb_seg_mux_scheduler.sv - self-checking bench for seg_mux_scheduler
module tb_seg_mux_scheduler;

`ifdef SEG_MUX_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam int ON_A = 4;
    localparam int BL_A = 2;
    localparam int ON_B = 3;
    localparam int BL_B = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] s0 = 4'h0;
    logic [3:0] s1 = 4'h0;

    logic [3:0] hex_a, hex_b;
    logic [1:0] an_a, an_b;
    logic       digit_a, digit_b, frame_a, frame_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_mux_scheduler #(.ON_CYCLES(ON_A), .BLANK_CYCLES(BL_A)) dut_a (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1),
        .hex(hex_a), .an(an_a), .digit(digit_a), .frame(frame_a)
    );

    seg_mux_scheduler #(.ON_CYCLES(ON_B), .BLANK_CYCLES(BL_B)) dut_b (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1),
        .hex(hex_b), .an(an_b), .digit(digit_b), .frame(frame_b)
    );

    // ---------------- reference model (cycle arithmetic) ----------------
    int         m_t  [2];
    logic [3:0] m_h0 [2];
    logic [3:0] m_h1 [2];

    function automatic int on_of(int i);
        return (i == 0) ? ON_A : ON_B;
    endfunction

    function automatic int blank_of(int i);
        if (!BLANK_EN) return 0;
        return (i == 0) ? BL_A : BL_B;
    endfunction

    function automatic int period_of(int i);
        return 2 * (on_of(i) + blank_of(i));
    endfunction

    task automatic model_edge(input int i, input logic r, input logic [3:0] a, input logic [3:0] b);
        int p;
        if (r) begin
            m_t[i]  = 0;
            m_h0[i] = 4'h0;
            m_h1[i] = 4'h0;
        end else begin
            m_t[i] = m_t[i] + 1;
            p = m_t[i] % period_of(i);
            if (p == 0) m_h0[i] = a;
            if (p == on_of(i) + blank_of(i)) m_h1[i] = b;
        end
    endtask

    // packed as {an[1:0], hex[3:0], digit, frame}
    function automatic logic [7:0] model_out(input int i);
        int p, on, bl;
        logic [1:0] an;
        logic [3:0] hx;
        logic       dg;
        on = on_of(i);
        bl = blank_of(i);
        p  = m_t[i] % period_of(i);
        if (p < on)               begin an = 2'b10; dg = 1'b0; end
        else if (p < on + bl)     begin an = 2'b11; dg = 1'b0; end
        else if (p < 2 * on + bl) begin an = 2'b01; dg = 1'b1; end
        else                      begin an = 2'b11; dg = 1'b1; end
        hx = dg ? m_h1[i] : m_h0[i];
        return {an, hx, dg, (p == 0)};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one clock edge, advance the model, check both DUTs.
    task automatic tick(input logic r, input logic [3:0] a, input logic [3:0] b);
        reset = r;
        s0    = a;
        s1    = b;
        @(posedge clk);
        model_edge(0, r, a, b);
        model_edge(1, r, a, b);
        #1;
        chk("model_a", {an_a, hex_a, digit_a, frame_a}, model_out(0));
        chk("model_b", {an_b, hex_b, digit_b, frame_b}, model_out(1));
    endtask

    // ---------------- startup vector table (instance A) ----------------
    typedef struct packed {
        logic       rst;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] an;
        logic [3:0] hex;
        logic       digit;
        logic       frame;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [1:0] an, input logic [3:0] hx,
                                input logic dg, input logic fr);
        vec_t v;
        v.rst = r; v.s0 = 4'h3; v.s1 = 4'hA;
        v.an = an; v.hex = hx; v.digit = dg; v.frame = fr;
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        int s_start;
        logic [3:0] a, b;
        logic r;

`ifdef SEG_MUX_BLANK_EN
        tbl[0]  = mk(1, 2'b10, 4'h0, 0, 1);
        tbl[1]  = mk(0, 2'b10, 4'h0, 0, 0);
        tbl[2]  = mk(0, 2'b10, 4'h0, 0, 0);
        tbl[3]  = mk(0, 2'b10, 4'h0, 0, 0);
        tbl[4]  = mk(0, 2'b11, 4'h0, 0, 0);
        tbl[5]  = mk(0, 2'b11, 4'h0, 0, 0);
        tbl[6]  = mk(0, 2'b01, 4'hA, 1, 0);
        tbl[7]  = mk(0, 2'b01, 4'hA, 1, 0);
        tbl[8]  = mk(0, 2'b01, 4'hA, 1, 0);
        tbl[9]  = mk(0, 2'b01, 4'hA, 1, 0);
        tbl[10] = mk(0, 2'b11, 4'hA, 1, 0);
        tbl[11] = mk(0, 2'b11, 4'hA, 1, 0);
        tbl[12] = mk(0, 2'b10, 4'h3, 0, 1);
`else
        tbl[0]  = mk(1, 2'b10, 4'h0, 0, 1);
        tbl[1]  = mk(0, 2'b10, 4'h0, 0, 0);
        tbl[2]  = mk(0, 2'b10, 4'h0, 0, 0);
        tbl[3]  = mk(0, 2'b10, 4'h0, 0, 0);
        tbl[4]  = mk(0, 2'b01, 4'hA, 1, 0);
        tbl[5]  = mk(0, 2'b01, 4'hA, 1, 0);
        tbl[6]  = mk(0, 2'b01, 4'hA, 1, 0);
        tbl[7]  = mk(0, 2'b01, 4'hA, 1, 0);
        tbl[8]  = mk(0, 2'b10, 4'h3, 0, 1);
        tbl[9]  = mk(0, 2'b10, 4'h3, 0, 0);
        tbl[10] = mk(0, 2'b10, 4'h3, 0, 0);
        tbl[11] = mk(0, 2'b10, 4'h3, 0, 0);
        tbl[12] = mk(0, 2'b01, 4'hA, 1, 0);
`endif

        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_h0[i] = 4'h0; m_h1[i] = 4'h0;
        end

        // Startup schedule
        for (int c = 0; c < 13; c++) begin
            tick(tbl[c].rst, tbl[c].s0, tbl[c].s1);
            chk($sformatf("startup_c%0d", c), {an_a, hex_a, digit_a, frame_a},
                {tbl[c].an, tbl[c].hex, tbl[c].digit, tbl[c].frame});
        end

        // Mid-display change of s1: the lit digit must not change
        s_start = ON_A + (BLANK_EN ? BL_A : 0);
        tick(1, 4'h3, 4'hA);
        for (int c = 1; c <= s_start + period_of(0); c++) begin
            tick(0, 4'h3, (c <= s_start + 1) ? 4'hA : 4'h5);
            if (c >= s_start && c < s_start + ON_A)
                chk($sformatf("hold_h1_c%0d", c), {4'h0, hex_a}, {4'h0, 4'hA});
            if (c == s_start + period_of(0))
                chk("recapture_h1", {4'h0, hex_a}, {4'h0, 4'h5});
        end

        // Mid-frame reset during SHOW1 then a full SHOW0
        tick(1, 4'h3, 4'hA);
        for (int c = 1; c <= 7; c++) tick(0, 4'h3, 4'hA);
        tick(1, 4'h3, 4'hA);
        chk("midreset", {an_a, hex_a, digit_a, frame_a}, {2'b10, 4'h0, 1'b0, 1'b1});
        for (int c = 1; c <= ON_A; c++) begin
            tick(0, 4'h3, 4'hA);
            chk($sformatf("show0_len_c%0d", c), {7'h0, an_a == 2'b10}, {7'h0, c < ON_A});
        end

        // Reset held for several edges stays frozen with frame=1
        for (int c = 0; c < 3; c++) begin
            tick(1, 4'h7, 4'h9);
            chk($sformatf("reset_hold_%0d", c), {an_a, hex_a, digit_a, frame_a},
                {2'b10, 4'h0, 1'b0, 1'b1});
        end

        // Randomized run against the model plus invariants
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            a = 4'($urandom);
            b = 4'($urandom);
            tick(r, a, b);
            chk("an_a_not_00", {7'h0, an_a == 2'b00}, 8'h0);
            chk("an_b_not_00", {7'h0, an_b == 2'b00}, 8'h0);
            if (an_a != 2'b11) chk("digit_a_vs_an", {7'h0, digit_a}, {7'h0, an_a[0]});
            if (an_b != 2'b11) chk("digit_b_vs_an", {7'h0, digit_b}, {7'h0, an_b[0]});
            if (!BLANK_EN) begin
                chk("an_a_never_11", {7'h0, an_a == 2'b11}, 8'h0);
                chk("an_b_never_11", {7'h0, an_b == 2'b11}, 8'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_mux_scheduler.md
# seg_mux_scheduler

Time-multiplexing scheduler that shares one external seven-segment decoder and a common segment bus between two digits of a dual display. It sits between the switch inputs and the hex-to-seven-segment decoder, alternating the selected nibble and the digit anode enables on a fixed schedule. An optional blanking interval between digits suppresses ghosting. The sequencing is a four-state FSM with a cycle counter and per-digit holding registers.

## Interface
- ON_CYCLES, 50000, cycles each digit is driven per frame; legal range is at least 2.
- BLANK_CYCLES, 1000, cycles of all-off between digits; legal range is at least 1. Used only when blanking is compiled in.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- s0  in  4  nibble for digit 0.
- s1  in  4  nibble for digit 1.
- hex  out  4  nibble presented to the shared decoder.
- an  out  2  anode enables, active-low; an[0] is digit 0 and an[1] is digit 1.
- digit  out  1  index of the digit currently owning the bus; 0 during SHOW0/BLANK0 and 1 during SHOW1/BLANK1.
- frame  out  1  one-cycle pulse on the first cycle of every SHOW0.

## Operation
- States: SHOW0, then BLANK0, then SHOW1, then BLANK1, then back to SHOW0.
- Cycle counter:
  - Width is $clog2(max(ON_CYCLES, BLANK_CYCLES)).
  - It is cleared on every state change.
  - SHOWn exits when count equals ON_CYCLES-1.
  - BLANKn exits when count equals BLANK_CYCLES-1.
- Holding registers h0 and h1:
  - h0 loads s0 on the clock edge that enters SHOW0.
  - h1 loads s1 on the clock edge that enters SHOW1.
  - Input changes at any other time are ignored until the next entry, so a digit never changes mid-display.
- Outputs are Moore functions of state and the holding registers only (no combinational path from s0/s1):
  - SHOW0: an=2'b10, hex=h0.
  - SHOW1: an=2'b01, hex=h1.
  - BLANK0: an=2'b11, hex holds h0.
  - BLANK1: an=2'b11, hex holds h1.
- frame = (state==SHOW0) && (count==0).
- Reset values, applied on the next edge whenever reset is high, including mid-frame:
  - state=SHOW0, count=0, h0=h1=4'h0.
  - Resulting outputs: an=2'b10, hex=4'h0, digit=0, frame=1.
  - The first SHOW0 after reset therefore displays 0, not s0.
- Reset held high for multiple cycles keeps the block frozen in the reset state with frame=1.
- It is never legal for both an bits to be 0.

## Timing
- With blanking, the frame period is exactly 2*(ON_CYCLES+BLANK_CYCLES) cycles; frame pulses are spaced by exactly that amount.
- Taking the first cycle after reset deasserts as cycle 0:
  - SHOW0 covers cycles 0..ON_CYCLES-1.
  - BLANK0 follows for BLANK_CYCLES cycles.
  - SHOW1 begins at cycle ON_CYCLES+BLANK_CYCLES.
- Capture latency: s0 must be stable on the edge entering SHOW0; hex reflects it in that first SHOW0 cycle.
- Counter wrap-around: the counter never exceeds its terminal value and clears on every state change.

## Configuration
- SEG_MUX_BLANK_EN defined:
  - The full four-state schedule above is used.
- SEG_MUX_BLANK_EN undefined:
  - BLANK0 and BLANK1 are not compiled; the FSM alternates SHOW0 and SHOW1 only.
  - BLANK_CYCLES is ignored.
  - Frame period is 2*ON_CYCLES.
  - an is never 2'b11 outside of reset.
  - Reset behaviour and capture rules are unchanged.

## Test plan
- Startup, ON_CYCLES=4, BLANK_CYCLES=2, s0=4'h3, s1=4'hA, reset released before cycle 0. Required response:
  - frame=1 at cycle 0 only.
  - Cycles 0-3: an=10, hex=0.
  - Cycles 4-5: an=11.
  - Cycles 6-9: an=01, hex=A, digit=1.
  - Cycles 10-11: an=11.
  - Cycle 12: frame=1, an=10, hex=3.
- Mid-display input change, same parameters: toggle s1 from A to 5 at cycle 7. Required response:
  - hex stays A through cycle 9.
  - hex is 5 at cycle 18, the next SHOW1.
- Mid-frame reset, same parameters: assert reset during cycle 7 (SHOW1) for one edge. Required response:
  - Next cycle: an=10, hex=0, frame=1.
  - The schedule restarts from SHOW0 with a full 4-cycle SHOW0.
- Blank disabled, SEG_MUX_BLANK_EN undefined, ON_CYCLES=3. Required response:
  - an alternates 10,10,10,01,01,01 and repeats.
  - Frame pulses spaced exactly 6 cycles.
  - an is never 11.
- Long run, defaults, 3 frames. Required response:
  - Frame spacing is 102000 cycles.
  - an is never 00 at any cycle.
  - digit matches an at every cycle.
